// File: rtl/reaper_exec_core.sv
// -----------------------------------------------------------------------------
// reaper_exec_core
//
// Execution core of the Reaper CPU: a registered clock divider, the opcode
// decoder that produces every datapath control strobe, and a zero-latency
// signed 32-bit ALU driven by the decoded ALU_Op.
//
// Parameters
//   DIV            Fast_Clock cycles per Slow_Clock half-period (1..65535)
//
// Ports
//   Fast_Clock     in   1   system clock, all state updates on rising edge
//   Reset          in   1   synchronous active-high reset (divider only)
//   Opcode         in   6   instruction opcode field, Instruction[31:26]
//   Input_1        in   32  signed ALU operand A
//   Input_2        in   32  signed ALU operand B
//   Slow_Clock     out  1   divided clock, registered, 50% duty
//   Result         out  32  signed ALU result
//   True           out  1   comparison flag (comparison ops only)
//   Reg_Write .. Halt  out 1 each  control strobes, combinational from Opcode
//   ALU_Op         out  5   ALU operation selected by the decoder
//   IO_Selection   out  2   IO port select
//   Draw_Select    out  2   draw primitive select
// -----------------------------------------------------------------------------
module reaper_exec_core #(
   parameter int DIV = 2
) (
   input  logic               Fast_Clock,
   input  logic               Reset,
   input  logic [5:0]         Opcode,
   input  logic signed [31:0] Input_1,
   input  logic signed [31:0] Input_2,
   output logic               Slow_Clock,
   output logic signed [31:0] Result,
   output logic               True,
   output logic               Reg_Write,
   output logic               ALU_Src,
   output logic               Long_Imm,
   output logic               Mem_Write,
   output logic               Mem_To_Reg,
   output logic               Branch,
   output logic               Jump_R,
   output logic               Jump_I,
   output logic               Stack_Enable,
   output logic               Stack_Write,
   output logic               IO_Enable,
   output logic               Change_Context,
   output logic               Halt,
   output logic [4:0]         ALU_Op,
   output logic [1:0]         IO_Selection,
   output logic [1:0]         Draw_Select
);

   localparam logic [15:0] LP_TERM = 16'(DIV - 1);

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_DIV  = 5'd3;
   localparam logic [4:0] OP_MOD  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_XOR  = 5'd7;
   localparam logic [4:0] OP_NOT  = 5'd8;
   localparam logic [4:0] OP_SLL  = 5'd9;
   localparam logic [4:0] OP_SRL  = 5'd10;
   localparam logic [4:0] OP_SRA  = 5'd11;
   localparam logic [4:0] OP_SLT  = 5'd12;
   localparam logic [4:0] OP_EQ   = 5'd13;
   localparam logic [4:0] OP_NE   = 5'd14;
   localparam logic [4:0] OP_GT   = 5'd15;
   localparam logic [4:0] OP_GE   = 5'd16;
   localparam logic [4:0] OP_LE   = 5'd17;
   localparam logic [4:0] OP_PASS = 5'd18;

   logic [15:0] r_count;
   logic        r_slow;
   logic        w_cond;

   // Clock divider: wrap the counter at DIV-1 and toggle Slow_Clock on that edge.
   always_ff @(posedge Fast_Clock) begin
      if (Reset) begin
         r_count <= 16'd0;
         r_slow  <= 1'b0;
      end else if (r_count == LP_TERM) begin
         r_count <= 16'd0;
         r_slow  <= ~r_slow;
      end else begin
         r_count <= r_count + 16'd1;
         r_slow  <= r_slow;
      end
   end

   assign Slow_Clock = r_slow;

   // Opcode decode: every strobe defaults low, each opcode group raises its own.
   always_comb begin
      Reg_Write      = 1'b0;
      ALU_Src        = 1'b0;
      Long_Imm       = 1'b0;
      Mem_Write      = 1'b0;
      Mem_To_Reg     = 1'b0;
      Branch         = 1'b0;
      Jump_R         = 1'b0;
      Jump_I         = 1'b0;
      Stack_Enable   = 1'b0;
      Stack_Write    = 1'b0;
      IO_Enable      = 1'b0;
      Change_Context = 1'b0;
      Halt           = 1'b0;
      ALU_Op         = 5'd0;
      IO_Selection   = 2'd0;
      Draw_Select    = 2'd0;
      case (Opcode) inside
         [6'h01:6'h13]: begin
            // Opcode[5] is 0 here, so 5-bit arithmetic gives Opcode-1 exactly.
            ALU_Op    = Opcode[4:0] - 5'd1;
            Reg_Write = 1'b1;
         end
         [6'h14:6'h26]: begin
            // Result lies in 0..18, so the mod-32 subtraction is exact.
            ALU_Op    = Opcode[4:0] - 5'd20;
            Reg_Write = 1'b1;
            ALU_Src   = 1'b1;
         end
         6'h27: begin
            ALU_Op    = OP_PASS;
            ALU_Src   = 1'b1;
            Long_Imm  = 1'b1;
            Reg_Write = 1'b1;
         end
         6'h28: begin
            ALU_Op     = OP_ADD;
            ALU_Src    = 1'b1;
            Mem_To_Reg = 1'b1;
            Reg_Write  = 1'b1;
         end
         6'h29: begin
            ALU_Op    = OP_ADD;
            ALU_Src   = 1'b1;
            Mem_Write = 1'b1;
         end
         6'h2A: begin
            Branch = 1'b1;
            ALU_Op = OP_EQ;
         end
         6'h2B: begin
            Branch = 1'b1;
            ALU_Op = OP_NE;
         end
         6'h2C: begin
            Branch = 1'b1;
            ALU_Op = OP_SLT;
         end
         6'h2D: begin
            Branch = 1'b1;
            ALU_Op = OP_GT;
         end
         6'h2E: begin
            Jump_R = 1'b1;
         end
         6'h2F: begin
            Jump_I   = 1'b1;
            Long_Imm = 1'b1;
         end
         6'h30: begin
            Jump_I       = 1'b1;
            Long_Imm     = 1'b1;
            Stack_Enable = 1'b1;
            Stack_Write  = 1'b1;
         end
         6'h31: begin
            Stack_Enable = 1'b1;
         end
         6'h32: begin
            IO_Enable    = 1'b1;
            IO_Selection = 2'd0;
            Reg_Write    = 1'b1;
         end
         6'h33: begin
            IO_Enable    = 1'b1;
            IO_Selection = 2'd1;
         end
         [6'h34:6'h36]: begin
            IO_Enable    = 1'b1;
            IO_Selection = 2'd2;
            // 0x34 has zero low bits, so Opcode-0x34 is just Opcode[1:0].
            Draw_Select  = Opcode[1:0];
         end
         6'h37: begin
            IO_Enable    = 1'b1;
            IO_Selection = 2'd3;
            Reg_Write    = 1'b1;
         end
         6'h38: begin
            Change_Context = 1'b1;
         end
         6'h3F: begin
            Halt = 1'b1;
         end
         default: begin
            ALU_Op = 5'd0;
         end
      endcase
   end

   // ALU: signed arithmetic, zero latency, divide-by-zero forced to 0.
   always_comb begin
      Result = 32'sd0;
      True   = 1'b0;
      w_cond = 1'b0;
      case (ALU_Op)
         OP_ADD:  Result = Input_1 + Input_2;
         OP_SUB:  Result = Input_1 - Input_2;
         OP_MUL:  Result = Input_1 * Input_2;
         OP_DIV: begin
            if (Input_2 == 32'sd0) begin
               Result = 32'sd0;
            end else begin
               Result = Input_1 / Input_2;
            end
         end
         OP_MOD: begin
            if (Input_2 == 32'sd0) begin
               Result = 32'sd0;
            end else begin
               Result = Input_1 % Input_2;
            end
         end
         OP_AND:  Result = Input_1 & Input_2;
         OP_OR:   Result = Input_1 | Input_2;
         OP_XOR:  Result = Input_1 ^ Input_2;
         OP_NOT:  Result = ~Input_1;
         OP_SLL:  Result = Input_1 << Input_2[4:0];
         OP_SRL:  Result = $signed($unsigned(Input_1) >> Input_2[4:0]);
         OP_SRA:  Result = Input_1 >>> Input_2[4:0];
         OP_SLT, OP_EQ, OP_NE, OP_GT, OP_GE, OP_LE: begin
            case (ALU_Op)
               OP_SLT:  w_cond = (Input_1 <  Input_2);
               OP_EQ:   w_cond = (Input_1 == Input_2);
               OP_NE:   w_cond = (Input_1 != Input_2);
               OP_GT:   w_cond = (Input_1 >  Input_2);
               OP_GE:   w_cond = (Input_1 >= Input_2);
               OP_LE:   w_cond = (Input_1 <= Input_2);
               default: w_cond = 1'b0;
            endcase
            Result = $signed({31'd0, w_cond});
            True   = w_cond;
         end
         OP_PASS: Result = Input_2;
         default: Result = 32'sd0;
      endcase
   end

endmodule

// File: tb/tb_reaper_exec_core.sv
// -----------------------------------------------------------------------------
// tb_reaper_exec_core
//
// Table-driven check of the decoder + ALU, followed by hand-written divider
// sequences (reset release, steady toggling, mid-high-phase reset).
// Expected values are pushed to scoreboard queues as stimulus is driven and
// popped when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_reaper_exec_core;

   localparam logic [12:0] F_RW = 13'h1000;
   localparam logic [12:0] F_AS = 13'h0800;
   localparam logic [12:0] F_LI = 13'h0400;
   localparam logic [12:0] F_MW = 13'h0200;
   localparam logic [12:0] F_MR = 13'h0100;
   localparam logic [12:0] F_BR = 13'h0080;
   localparam logic [12:0] F_JR = 13'h0040;
   localparam logic [12:0] F_JI = 13'h0020;
   localparam logic [12:0] F_SE = 13'h0010;
   localparam logic [12:0] F_SW = 13'h0008;
   localparam logic [12:0] F_IO = 13'h0004;
   localparam logic [12:0] F_CC = 13'h0002;
   localparam logic [12:0] F_HL = 13'h0001;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        tru;
      logic [21:0] ctrl;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        tru;
      logic [21:0] ctrl;
   } exp_t;

   logic               Fast_Clock = 1'b0;
   logic               Reset;
   logic [5:0]         Opcode;
   logic signed [31:0] Input_1;
   logic signed [31:0] Input_2;
   logic               Slow_Clock;
   logic signed [31:0] Result;
   logic               True;
   logic Reg_Write, ALU_Src, Long_Imm, Mem_Write, Mem_To_Reg, Branch, Jump_R;
   logic Jump_I, Stack_Enable, Stack_Write, IO_Enable, Change_Context, Halt;
   logic [4:0] ALU_Op;
   logic [1:0] IO_Selection;
   logic [1:0] Draw_Select;

   int n_checks = 0;
   int n_fail   = 0;

   vec_t vecs[32];
   int   n_vec = 0;
   exp_t sb_q[$];
   logic sb_slow[$];

   always #5 Fast_Clock = ~Fast_Clock;

   reaper_exec_core #(.DIV(2)) dut (
      .Fast_Clock     (Fast_Clock),
      .Reset          (Reset),
      .Opcode         (Opcode),
      .Input_1        (Input_1),
      .Input_2        (Input_2),
      .Slow_Clock     (Slow_Clock),
      .Result         (Result),
      .True           (True),
      .Reg_Write      (Reg_Write),
      .ALU_Src        (ALU_Src),
      .Long_Imm       (Long_Imm),
      .Mem_Write      (Mem_Write),
      .Mem_To_Reg     (Mem_To_Reg),
      .Branch         (Branch),
      .Jump_R         (Jump_R),
      .Jump_I         (Jump_I),
      .Stack_Enable   (Stack_Enable),
      .Stack_Write    (Stack_Write),
      .IO_Enable      (IO_Enable),
      .Change_Context (Change_Context),
      .Halt           (Halt),
      .ALU_Op         (ALU_Op),
      .IO_Selection   (IO_Selection),
      .Draw_Select    (Draw_Select)
   );

   function automatic logic [21:0] ctl(input logic [12:0] f, input logic [4:0] aop,
                                       input logic [1:0] ios, input logic [1:0] drw);
      return {f, aop, ios, drw};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] res, input logic tru,
                      input logic [21:0] c);
      vecs[n_vec] = '{name, op, a, b, res, tru, c};
      n_vec++;
   endtask

   task automatic slow_step(input string name, input logic exp);
      logic e;
      sb_slow.push_back(exp);
      @(posedge Fast_Clock);
      #1;
      e = sb_slow.pop_front();
      check(name, {31'd0, Slow_Clock}, {31'd0, e});
   endtask

   initial begin
      exp_t e;
      logic [21:0] act_ctrl;

      add("nop",      6'h00, 32'h0, 32'h0, 32'h0, 1'b0, 22'h0);
      add("add_wrap", 6'h01, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, ctl(F_RW, 5'd0, 2'd0, 2'd0));
      add("sub",      6'h02, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, ctl(F_RW, 5'd1, 2'd0, 2'd0));
      add("mul",      6'h03, 32'h12345678, 32'h10, 32'h23456780, 1'b0, ctl(F_RW, 5'd2, 2'd0, 2'd0));
      add("div",      6'h04, -32'sd7, 32'sd2, -32'sd3, 1'b0, ctl(F_RW, 5'd3, 2'd0, 2'd0));
      add("mod",      6'h05, -32'sd7, 32'sd2, -32'sd1, 1'b0, ctl(F_RW, 5'd4, 2'd0, 2'd0));
      add("div_by0",  6'h04, -32'sd7, 32'sd0, 32'h0, 1'b0, ctl(F_RW, 5'd3, 2'd0, 2'd0));
      add("mod_by0",  6'h05, -32'sd7, 32'sd0, 32'h0, 1'b0, ctl(F_RW, 5'd4, 2'd0, 2'd0));
      add("sra",      6'h0C, 32'h80000000, 32'h24, 32'hF8000000, 1'b0, ctl(F_RW, 5'd11, 2'd0, 2'd0));
      add("srl",      6'h0B, 32'h80000000, 32'h24, 32'h08000000, 1'b0, ctl(F_RW, 5'd10, 2'd0, 2'd0));
      add("sll",      6'h0A, 32'h1, 32'h21, 32'h2, 1'b0, ctl(F_RW, 5'd9, 2'd0, 2'd0));
      add("not",      6'h09, 32'h0F0F0000, 32'h0, 32'hF0F0FFFF, 1'b0, ctl(F_RW, 5'd8, 2'd0, 2'd0));
      add("gt",       6'h10, -32'sd1, -32'sd2, 32'h1, 1'b1, ctl(F_RW, 5'd15, 2'd0, 2'd0));
      add("le",       6'h12, -32'sd1, -32'sd1, 32'h1, 1'b1, ctl(F_RW, 5'd17, 2'd0, 2'd0));
      add("passb",    6'h13, 32'h7, 32'h55, 32'h55, 1'b0, ctl(F_RW, 5'd18, 2'd0, 2'd0));
      add("xori",     6'h1B, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, ctl(F_RW | F_AS, 5'd7, 2'd0, 2'd0));
      add("li",       6'h27, 32'h1, 32'hABCD, 32'hABCD, 1'b0, ctl(F_RW | F_AS | F_LI, 5'd18, 2'd0, 2'd0));
      add("lw",       6'h28, 32'd100, 32'd4, 32'd104, 1'b0, ctl(F_RW | F_AS | F_MR, 5'd0, 2'd0, 2'd0));
      add("sw",       6'h29, 32'd8, 32'd4, 32'd12, 1'b0, ctl(F_AS | F_MW, 5'd0, 2'd0, 2'd0));
      add("blt_t",    6'h2C, -32'sd5, 32'sd3, 32'h1, 1'b1, ctl(F_BR, 5'd12, 2'd0, 2'd0));
      add("blt_f",    6'h2C, 32'sd3, -32'sd5, 32'h0, 1'b0, ctl(F_BR, 5'd12, 2'd0, 2'd0));
      add("beq",      6'h2A, 32'd9, 32'd9, 32'h1, 1'b1, ctl(F_BR, 5'd13, 2'd0, 2'd0));
      add("jal",      6'h30, 32'h0, 32'h0, 32'h0, 1'b0, ctl(F_JI | F_LI | F_SE | F_SW, 5'd0, 2'd0, 2'd0));
      add("ret",      6'h31, 32'h0, 32'h0, 32'h0, 1'b0, ctl(F_SE, 5'd0, 2'd0, 2'd0));
      add("jr",       6'h2E, 32'h0, 32'h0, 32'h0, 1'b0, ctl(F_JR, 5'd0, 2'd0, 2'd0));
      add("out",      6'h33, 32'h0, 32'h0, 32'h0, 1'b0, ctl(F_IO, 5'd0, 2'd1, 2'd0));
      add("draw1",    6'h35, 32'h0, 32'h0, 32'h0, 1'b0, ctl(F_IO, 5'd0, 2'd2, 2'd1));
      add("key",      6'h37, 32'h0, 32'h0, 32'h0, 1'b0, ctl(F_IO | F_RW, 5'd0, 2'd3, 2'd0));
      add("ctx",      6'h38, 32'h0, 32'h0, 32'h0, 1'b0, ctl(F_CC, 5'd0, 2'd0, 2'd0));
      add("hlt",      6'h3F, 32'h0, 32'h0, 32'h0, 1'b0, ctl(F_HL, 5'd0, 2'd0, 2'd0));
      add("nop3a",    6'h3A, 32'h0, 32'h0, 32'h0, 1'b0, 22'h0);

      Reset   = 1'b1;
      Opcode  = 6'h00;
      Input_1 = 32'sd0;
      Input_2 = 32'sd0;

      // Reset state of the divider.
      repeat (3) @(posedge Fast_Clock);
      #1;
      check("slow_reset", {31'd0, Slow_Clock}, 32'd0);

      // Combinational decode + ALU vectors (reset still high: must not matter).
      for (int i = 0; i < n_vec; i++) begin
         sb_q.push_back('{vecs[i].name, vecs[i].res, vecs[i].tru, vecs[i].ctrl});
         Opcode  = vecs[i].op;
         Input_1 = vecs[i].a;
         Input_2 = vecs[i].b;
         #1;
         e = sb_q.pop_front();
         act_ctrl = {Reg_Write, ALU_Src, Long_Imm, Mem_Write, Mem_To_Reg, Branch, Jump_R,
                     Jump_I, Stack_Enable, Stack_Write, IO_Enable, Change_Context, Halt,
                     ALU_Op, IO_Selection, Draw_Select};
         check({e.name, "_result"}, Result, e.res);
         check({e.name, "_true"}, {31'd0, True}, {31'd0, e.tru});
         check({e.name, "_ctrl"}, {10'd0, act_ctrl}, {10'd0, e.ctrl});
      end

      // Divider from reset release: after edge k the level is (k/DIV)%2.
      @(negedge Fast_Clock);
      Reset = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         slow_step($sformatf("slow_k%0d", k), 1'(((k / 2) % 2) == 1));
      end

      // Slow_Clock is high (first cycle of high phase); reset forces 0 next edge.
      @(negedge Fast_Clock);
      Reset = 1'b1;
      slow_step("slow_midreset", 1'b0);
      slow_step("slow_hold", 1'b0);
      @(negedge Fast_Clock);
      Reset = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         slow_step($sformatf("slow_re_k%0d", k), 1'(((k / 2) % 2) == 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reaper_exec_core.md
REAPER_EXEC_CORE -- requirements
Module: reaper_exec_core

Interface
REQ-001 Parameter: DIV, default 2, meaning Fast_Clock cycles per Slow_Clock half-period; legal range 1..65535.
REQ-002 Fast_Clock  in  1  single system clock; all state updates on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Opcode  in  6  instruction opcode field, Instruction[31:26].
REQ-005 Input_1 / Input_2  in  32 each  signed ALU operands A / B.
REQ-006 Slow_Clock  out  1  divided clock, registered.
REQ-007 Result  out  32  signed ALU result; True  out  1  comparison flag.
REQ-008 Control outputs, all combinational from Opcode: Reg_Write, ALU_Src, Long_Imm, Mem_Write, Mem_To_Reg, Branch, Jump_R, Jump_I, Stack_Enable, Stack_Write, IO_Enable, Change_Context, Halt (1 bit each); ALU_Op (5 bits); IO_Selection (2 bits); Draw_Select (2 bits).
REQ-009 The internal ALU_Op, not the Opcode, drives the ALU.

Function -- clock divider
REQ-010 16-bit counter increments each Fast_Clock; at DIV-1 it wraps to 0 and Slow_Clock toggles on that same edge.
REQ-011 Slow_Clock period = 2*DIV Fast_Clock cycles with 50% duty; first rising edge 2*DIV-... specifically DIV cycles after Reset deasserts.
Function -- ALU (combinational, zero latency)
REQ-012 ALU_Op encoding: 0 ADD, 1 SUB, 2 MUL (low 32 bits), 3 DIV (signed, truncating), 4 MOD (signed, sign of A), 5 AND, 6 OR, 7 XOR, 8 NOT A, 9 SLL A by B[4:0], 10 SRL, 11 SRA, 12 SLT, 13 EQ, 14 NE, 15 GT, 16 GE, 17 LE, 18 PASS B.
REQ-013 ADD/SUB/MUL wrap modulo 2^32 with no overflow flag.
REQ-014 DIV or MOD with B=0 yields Result 0.
REQ-015 Comparisons 12-17 are signed; Result = {31'b0, cond}; True = cond.
REQ-016 For non-comparison ops True = 0; ALU_Op 19-31 yields Result 0, True 0.
Function -- control decode (every unlisted output 0)
REQ-017 0x00 NOP: all outputs 0.
REQ-018 0x01-0x13 register ALU: ALU_Op = Opcode-1, Reg_Write = 1, ALU_Src = 0.
REQ-019 0x14-0x26 immediate ALU: ALU_Op = Opcode-0x14, Reg_Write = 1, ALU_Src = 1.
REQ-020 0x27 LI: ALU_Op = 18, ALU_Src = 1, Long_Imm = 1, Reg_Write = 1.
REQ-021 0x28 LW: ALU_Op = 0, ALU_Src = 1, Mem_To_Reg = 1, Reg_Write = 1. 0x29 SW: ALU_Op = 0, ALU_Src = 1, Mem_Write = 1.
REQ-022 Branches (Branch = 1, ALU_Src = 0): 0x2A BEQ ALU_Op 13; 0x2B BNE ALU_Op 14; 0x2C BLT ALU_Op 12; 0x2D BGT ALU_Op 15.
REQ-023 0x2E JR: Jump_R = 1. 0x2F J: Jump_I = 1, Long_Imm = 1. 0x30 JAL: Jump_I = 1, Long_Imm = 1, Stack_Enable = 1, Stack_Write = 1. 0x31 RET: Stack_Enable = 1, Stack_Write = 0.
REQ-024 0x32 IN: IO_Enable = 1, IO_Selection = 0, Reg_Write = 1. 0x33 OUT: IO_Enable = 1, IO_Selection = 1.
REQ-025 0x34-0x36 DRAW: IO_Enable = 1, IO_Selection = 2, Draw_Select = Opcode-0x34.
REQ-026 0x37 KEY: IO_Enable = 1, IO_Selection = 3, Reg_Write = 1. 0x38 CTX: Change_Context = 1. 0x3F HLT: Halt = 1.
REQ-027 0x39-0x3E decode as NOP.

Reset
REQ-028 Reset sampled high on a Fast_Clock edge sets counter = 0 and Slow_Clock = 0, including when asserted mid-period; Reset takes priority over wrap/toggle.
REQ-029 Reset does not affect the ALU or control decode; both remain purely combinational.

Verification
REQ-030 DIV=2, Reset high 3 cycles then low -> Slow_Clock 0 for 2 cycles, 1 for 2, repeats with period 4; reasserting Reset mid-high-phase forces 0 on the next edge.
REQ-031 Opcode 0x01, A=0x7FFFFFFF, B=1 -> Result 0x80000000, True 0, Reg_Write 1, ALU_Src 0.
REQ-032 Opcode 0x2C (BLT), A=-5, B=3 -> Branch 1, ALU_Op 12, Result 1, True 1; A=3, B=-5 -> Result 0, True 0.
REQ-033 ALU_Op 3 with A=-7, B=2 -> Result -3; ALU_Op 4 gives -1; B=0 gives Result 0 for both ops.
REQ-034 Opcode 0x30 (JAL) -> Jump_I 1, Long_Imm 1, Stack_Enable 1, Stack_Write 1, all other outputs 0; 0x3F -> Halt only; 0x3A -> all outputs 0.
REQ-035 ALU_Op 11, A=0x80000000, B=0x24 -> shift amount 4, Result 0xF8000000.
